// File: rtl/mem_bus_pkg.sv
// Shared definitions for the TinyQV-style peripheral data bus: size codes,
// initiator states and the size-derived address step and read-data mask.
package mem_bus_pkg;

  localparam logic [1:0] SZ_8    = 2'b00;
  localparam logic [1:0] SZ_16   = 2'b01;
  localparam logic [1:0] SZ_32   = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    IDLE_GAP
  } bus_state_t;

  // Byte distance between consecutive beats of a burst.
  function automatic logic [2:0] size_incr(input logic [1:0] size);
    case (size)
      SZ_8:    return 3'd1;
      SZ_16:   return 3'd2;
      SZ_32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_8:    return 32'h0000_00FF;
      SZ_16:   return 32'h0000_FFFF;
      SZ_32:   return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_initiator.sv
// Single-command bus initiator: turns a valid/ready command into held
// requests toward a latch-RAM style responder, with read bursts and a timeout.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS      = 5,
  parameter int COUNT_BITS     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_size,
  input  logic [ADDR_BITS-1:0]  cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [COUNT_BITS-1:0] cmd_count,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_last,
  output logic                  rsp_error,
  output logic [ADDR_BITS-1:0]  addr_out,
  output logic [31:0]           wdata_out,
  output logic [1:0]            data_write_n,
  output logic [1:0]            data_read_n,
  input  logic [31:0]           data_in,
  input  logic                  data_ready
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);

  bus_state_t            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [COUNT_BITS-1:0] beats_q, beats_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  first_q, first_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [31:0]           wdata_d, rdata_d;
  logic [1:0]            dwn_d, drn_d;
  logic                  rsp_valid_d, rsp_last_d, rsp_error_d, cmd_ready_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      size_q       <= SZ_8;
      write_q      <= 1'b0;
      beats_q      <= '0;
      tmo_q        <= '0;
      first_q      <= 1'b0;
      addr_out     <= '0;
      wdata_out    <= '0;
      data_write_n <= SZ_NONE;
      data_read_n  <= SZ_NONE;
      rsp_valid    <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_rdata    <= '0;
      cmd_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      write_q      <= write_d;
      beats_q      <= beats_d;
      tmo_q        <= tmo_d;
      first_q      <= first_d;
      addr_out     <= addr_d;
      wdata_out    <= wdata_d;
      data_write_n <= dwn_d;
      data_read_n  <= drn_d;
      rsp_valid    <= rsp_valid_d;
      rsp_last     <= rsp_last_d;
      rsp_error    <= rsp_error_d;
      rsp_rdata    <= rdata_d;
      cmd_ready    <= cmd_ready_d;
    end
  end

  // Every output is computed one cycle ahead so the bus pins come straight from flops.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    write_d     = write_q;
    beats_d     = beats_q;
    tmo_d       = tmo_q;
    first_d     = 1'b0;
    addr_d      = addr_out;
    wdata_d     = wdata_out;
    dwn_d       = data_write_n;
    drn_d       = data_read_n;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_error_d = 1'b0;
    rdata_d     = rsp_rdata;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_size != SZ_NONE) begin
          state_d = REQ;
          size_d  = cmd_size;
          write_d = cmd_write;
          beats_d = cmd_write ? '0 : cmd_count;
          tmo_d   = TMO_LOAD;
          first_d = 1'b1;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) dwn_d = cmd_size;
          else           drn_d = cmd_size;
        end
      end

      // The first REQ cycle still sees the responder's previous ready, so skip it.
      REQ: begin
        if (!first_q && data_ready) begin
          dwn_d       = SZ_NONE;
          drn_d       = SZ_NONE;
          rsp_valid_d = 1'b1;
          rdata_d     = write_q ? 32'h0 : (data_in & size_mask(size_q));
          if (beats_q == '0) begin
            rsp_last_d = 1'b1;
            state_d    = IDLE_GAP;
          end else begin
            beats_d = beats_q - 1'b1;
            state_d = GAP;
          end
        end else if (tmo_q == 8'd0) begin
          dwn_d       = SZ_NONE;
          drn_d       = SZ_NONE;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_error_d = 1'b1;
          rdata_d     = 32'h0;
          state_d     = IDLE_GAP;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end

      GAP: begin
        state_d = REQ;
        addr_d  = addr_out + ADDR_BITS'(size_incr(size_q));
        tmo_d   = TMO_LOAD;
        first_d = 1'b1;
        if (write_q) dwn_d = size_q;
        else         drn_d = size_q;
      end

      IDLE_GAP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

endmodule
